// File: rtl/io_bank_pkg.sv
// Shared definitions for the bidirectional pad bank: per-channel config layout and mode encoding.
package io_bank_pkg;

  localparam int unsigned CFG_BITS_PER_CH = 4;
  localparam int unsigned CFG_MODE_LSB    = 0;
  localparam int unsigned CFG_MODE_MSB    = 1;
  localparam int unsigned CFG_INV_BIT     = 2;
  localparam int unsigned CFG_FORCE_Z_BIT = 3;

  typedef enum logic [1:0] {
    ModeBypass = 2'b00,
    ModeOreg   = 2'b01,
    ModeIsync  = 2'b10,
    ModeBoth   = 2'b11
  } io_mode_e;

  typedef struct packed {
    logic     force_z;
    logic     inv;
    io_mode_e mode;
  } ch_cfg_t;

  function automatic ch_cfg_t decode_cfg(input logic [CFG_BITS_PER_CH-1:0] bits);
    ch_cfg_t c;
    c.mode    = io_mode_e'(bits[CFG_MODE_MSB:CFG_MODE_LSB]);
    c.inv     = bits[CFG_INV_BIT];
    c.force_z = bits[CFG_FORCE_Z_BIT];
    return c;
  endfunction

endpackage

// File: rtl/io_channel.sv
// One bidirectional pad channel: optional output register, input synchronizer, and
// optional debounce on Q (built only when IO_DEBOUNCE_EN is defined).
module io_channel
  import io_bank_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2
`ifdef IO_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE_CYC = 8
`endif
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CFG_BITS_PER_CH-1:0] i_cfg,
  input  logic                       i_data,
  input  logic                       i_tri,
  input  logic                       i_pad_data,
  output logic                       o_pad_data,
  output logic                       o_pad_tri,
  output logic                       o_data,
  output logic                       o_q
);

  ch_cfg_t                w_cfg;
  logic                   w_oreg;
  logic                   w_isync;
  logic                   w_sync;
  logic                   r_i;
  logic                   r_t;
  logic [SYNC_STAGES-1:0] r_sync;

  assign w_cfg   = decode_cfg(i_cfg);
  assign w_oreg  = (w_cfg.mode == ModeOreg) || (w_cfg.mode == ModeBoth);
  assign w_isync = (w_cfg.mode == ModeIsync) || (w_cfg.mode == ModeBoth);
  assign w_sync  = r_sync[SYNC_STAGES-1];

  // Registers run in every mode so a mode switch never sees stale or cleared state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_i    <= 1'b0;
      r_t    <= 1'b1;
      r_sync <= '0;
    end else begin
      r_i    <= i_data;
      r_t    <= i_tri;
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad_data};
    end
  end

  always_comb begin
    o_pad_data = w_oreg ? r_i : i_data;
    o_pad_tri  = (w_oreg ? r_t : i_tri) | w_cfg.force_z | i_rst;
    o_data     = (w_isync ? w_sync : i_pad_data) ^ w_cfg.inv;
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            r_q;

  // Change detect looks one stage ahead so the count restarts on the edge the synced value moves.
  always_comb begin
    if (r_sync[SYNC_STAGES-1] != r_sync[SYNC_STAGES-2]) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntMax) begin
      w_cnt_d = r_cnt;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      if (w_cnt_d == CntMax) begin
        r_q <= w_sync ^ w_cfg.inv;
      end
    end
  end

  assign o_q = r_q;
`else
  assign o_q = w_sync ^ w_cfg.inv;
`endif

endmodule

// File: rtl/io_n_bidirectional_reg.sv
// Bank of NUM_CH independent bidirectional pad channels with per-channel static config.
// Define IO_DEBOUNCE_EN to build the Q debounce counters.
module io_n_bidirectional_reg
  import io_bank_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 8
) (
  input  logic                              UserCLK,
  input  logic                              UserRST,
  input  logic [NUM_CH-1:0]                 I,
  input  logic [NUM_CH-1:0]                 T,
  output logic [NUM_CH-1:0]                 O,
  output logic [NUM_CH-1:0]                 Q,
  output logic [NUM_CH-1:0]                 I_top,
  output logic [NUM_CH-1:0]                 T_top,
  input  logic [NUM_CH-1:0]                 O_top,
  input  logic [CFG_BITS_PER_CH*NUM_CH-1:0] ConfigBits
);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("NUM_CH must be within 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be within 2..4");
  end
  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYC must be within 1..255");
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    io_channel #(
      .SYNC_STAGES (SYNC_STAGES)
`ifdef IO_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
`endif
    ) u_ch (
      .i_clk     (UserCLK),
      .i_rst     (UserRST),
      .i_cfg     (ConfigBits[k*CFG_BITS_PER_CH +: CFG_BITS_PER_CH]),
      .i_data    (I[k]),
      .i_tri     (T[k]),
      .i_pad_data(O_top[k]),
      .o_pad_data(I_top[k]),
      .o_pad_tri (T_top[k]),
      .o_data    (O[k]),
      .o_q       (Q[k])
    );
  end

endmodule
